program_counter: RTL and testbench

Architectural program-counter register (`pc`) at the head of the CPU fetch stage. Each clock it captures the next-PC value computed upstream (sequential, branch or jump target) and presents it to instruction fetch. It also supplies the sequential successor address, a misalignment flag and a load counter for debug.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/pc_adder.sv | 14 +
 rtl/program_counter.sv | 41 ++++
 tb/tb_program_counter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, address type,
// default reset vector and instruction size in bytes.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;
    localparam int    INSN_BYTES   = 4;

endpackage

// File: rtl/pc_adder.sv
// Combinational address + INSN_BYTES, wraps modulo 2^W.
// Ports: addr (in, W), sum (out, W).
module pc_adder
    import cpu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] addr,
    output logic [W-1:0] sum
);

    assign sum = addr + W'(INSN_BYTES);

endmodule

// File: rtl/program_counter.sv
// Fetch-stage PC register with successor address, misalignment flag
// and load counter.
// Ports: clk, rst_n (sync, active-low), stall, pc_in -> pc_out,
//        pc_plus4, misaligned, load_count.
module program_counter
    import cpu_pkg::*;
#(
    parameter int              XLEN         = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic [31:0]     load_count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out     <= RESET_VECTOR;
            misaligned <= 1'b0;
            load_count <= 32'd0;
        end else if (!stall) begin
            // Low bits dropped; the flag records that they were set.
            pc_out     <= {pc_in[XLEN-1:2], 2'b00};
            misaligned <= (pc_in[1:0] != 2'b00);
            load_count <= load_count + 32'd1;
        end
    end

    pc_adder #(
        .W (XLEN)
    ) u_pc_adder (
        .addr (pc_out),
        .sum  (pc_plus4)
    );

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter.
// Expected values are hand-computed constants.
module tb_program_counter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] load_count;

    int n_checks = 0;
    int n_errors = 0;

    program_counter #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag,
                             input logic [31:0] e_pc,
                             input logic        e_mis,
                             input logic [31:0] e_cnt);
        check({tag, ".pc"}, pc_out, e_pc);
        check({tag, ".plus4"}, pc_plus4, e_pc + 32'd4);
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
        check({tag, ".cnt"}, load_count, e_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        pc_in = 32'h0000_1234;
        step();
        step();
        check_all("reset", 32'h0, 1'b0, 32'd0);

        rst_n = 1'b1;
        pc_in = 32'h4;
        step();
        check_all("seq1", 32'h4, 1'b0, 32'd1);
        pc_in = 32'h8;
        step();
        check_all("seq2", 32'h8, 1'b0, 32'd2);

        stall = 1'b1;
        pc_in = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall", 32'h8, 1'b0, 32'd2);
        end
        stall = 1'b0;
        step();
        check_all("unstall", 32'h100, 1'b0, 32'd3);

        pc_in = 32'h0000_0107;
        step();
        check_all("mis1", 32'h104, 1'b1, 32'd4);
        stall = 1'b1;
        pc_in = 32'h108;
        step();
        check_all("mis_hold", 32'h104, 1'b1, 32'd4);
        stall = 1'b0;
        step();
        check_all("mis0", 32'h108, 1'b0, 32'd5);

        pc_in = 32'hFFFF_FFFC;
        step();
        check("wrap.pc", pc_out, 32'hFFFF_FFFC);
        check("wrap.plus4", pc_plus4, 32'h0);
        check("wrap.cnt", load_count, 32'd6);
        pc_in = pc_plus4;
        step();
        check_all("wrap_fb", 32'h0, 1'b0, 32'd7);

        pc_in = 32'h40;
        step();
        check_all("pre_rst", 32'h40, 1'b0, 32'd8);
        stall = 1'b1;
        pc_in = 32'h200;
        rst_n = 1'b0;
        step();
        check_all("rst_stall", 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step();
        check_all("post_rst_stall", 32'h0, 1'b0, 32'd0);
        stall = 1'b0;
        pc_in = 32'h3;
        step();
        check_all("first_load", 32'h0, 1'b1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
